// File: rtl/cfu_cmd_bridge_pkg.sv
// Shared types and widths for the CFU command bridge.
package cfu_bridge_pkg;
  localparam int CFU_ID_W   = 10;
  localparam int CFU_DATA_W = 32;

  typedef struct packed {
    logic [CFU_ID_W-1:0]   function_id;
    logic [CFU_DATA_W-1:0] inputs_0;
    logic [CFU_DATA_W-1:0] inputs_1;
  } cfu_cmd_t;

  localparam int CFU_CMD_W = $bits(cfu_cmd_t);
endpackage

// File: rtl/cfu_cmd_bridge_if.sv
// One CFU cmd/rsp channel; master issues commands and consumes responses.
interface cfu_cmd_bridge_if;
  logic                                   cmd_valid;
  logic                                   cmd_ready;
  logic [cfu_bridge_pkg::CFU_ID_W-1:0]    cmd_function_id;
  logic [cfu_bridge_pkg::CFU_DATA_W-1:0]  cmd_inputs_0;
  logic [cfu_bridge_pkg::CFU_DATA_W-1:0]  cmd_inputs_1;
  logic                                   rsp_valid;
  logic                                   rsp_ready;
  logic [cfu_bridge_pkg::CFU_DATA_W-1:0]  rsp_outputs_0;

  modport master (
    output cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_outputs_0
  );
endinterface

// File: rtl/cfu_cmd_bridge_fifo.sv
// Registered synchronous FIFO, no fall-through; full/empty come from the count.
module cfu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    ptr_inc = (ptr == LAST_PTR) ? {PW{1'b0}} : ptr + PW'(1'b1);
  endfunction

  assign w_push  = i_push && (r_count != CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != {CW{1'b0}});
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // storage is cleared on reset so an empty FIFO presents a zero head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/cfu_cmd_bridge.sv
// CPU-to-CFU bridge: queued commands, buffered responses, credit-limited issue
// so the core's response can always be accepted.
module cfu_cmd_bridge
  import cfu_bridge_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  cfu_cmd_bridge_if.slave              cpu,
  cfu_cmd_bridge_if.master             core,
  output logic [$clog2(CMD_DEPTH):0]   cmd_level,
  output logic [$clog2(RSP_DEPTH):0]   credits,
  output logic                         err_unexpected_rsp
);
  localparam int LW = $clog2(CMD_DEPTH) + 1;
  localparam int KW = $clog2(RSP_DEPTH) + 1;

  cfu_cmd_t       w_cmd_in;
  cfu_cmd_t       w_cmd_head;
  logic [KW-1:0]  w_rsp_count;
  logic [KW-1:0]  r_credits;
  logic [KW-1:0]  r_outstanding;
  logic           r_err;
  logic           w_cmd_fire;
  logic           w_issue_fire;
  logic           w_rsp_fire;
  logic           w_rsp_accept;
  logic           w_unexpected;

  assign w_cmd_in = '{function_id: cpu.cmd_function_id,
                      inputs_0:    cpu.cmd_inputs_0,
                      inputs_1:    cpu.cmd_inputs_1};

  assign cpu.cmd_ready  = (cmd_level != LW'(CMD_DEPTH));
  assign core.cmd_valid = (cmd_level != {LW{1'b0}}) && (r_credits != {KW{1'b0}});
  assign cpu.rsp_valid  = (w_rsp_count != {KW{1'b0}});
  assign core.rsp_ready = 1'b1;

  assign core.cmd_function_id = w_cmd_head.function_id;
  assign core.cmd_inputs_0    = w_cmd_head.inputs_0;
  assign core.cmd_inputs_1    = w_cmd_head.inputs_1;

  assign w_cmd_fire   = cpu.cmd_valid && cpu.cmd_ready;
  assign w_issue_fire = core.cmd_valid && core.cmd_ready;
  assign w_rsp_fire   = cpu.rsp_valid && cpu.rsp_ready;
  // a combinational core answers in the same cycle its command fires
  assign w_rsp_accept = core.rsp_valid && ((r_outstanding != {KW{1'b0}}) || w_issue_fire);
  assign w_unexpected = core.rsp_valid && (r_outstanding == {KW{1'b0}}) && !w_issue_fire;

  assign credits            = r_credits;
  assign err_unexpected_rsp = r_err;

  cfu_sync_fifo #(.WIDTH(CFU_CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_cmd_fire),
    .i_data  (w_cmd_in),
    .i_pop   (w_issue_fire),
    .o_head  (w_cmd_head),
    .o_count (cmd_level)
  );

  cfu_sync_fifo #(.WIDTH(CFU_DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_rsp_accept),
    .i_data  (core.rsp_outputs_0),
    .i_pop   (w_rsp_fire),
    .o_head  (cpu.rsp_outputs_0),
    .o_count (w_rsp_count)
  );

  // credits: spent on issue, returned when the CPU takes a response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credits <= KW'(RSP_DEPTH);
    end else begin
      case ({w_issue_fire, w_rsp_fire})
        2'b10:   r_credits <= r_credits - KW'(1'b1);
        2'b01:   r_credits <= r_credits + KW'(1'b1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // commands issued to the core and not yet answered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstanding <= {KW{1'b0}};
    end else begin
      case ({w_issue_fire, w_rsp_accept})
        2'b10:   r_outstanding <= r_outstanding + KW'(1'b1);
        2'b01:   r_outstanding <= r_outstanding - KW'(1'b1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // sticky until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_unexpected) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end
endmodule

// File: tb/tb_cfu_cmd_bridge.sv
// Randomised bench for cfu_cmd_bridge with a combinational XOR core and an
// in-order scoreboard built from handshake counts.
module tb_cfu_cmd_bridge;
  import cfu_bridge_pkg::*;

  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  cmd_level;
  logic [1:0]  credits;
  logic        err_unexpected_rsp;
  logic        inj_valid = 1'b0;
  logic [31:0] inj_data = 32'h0;

  cfu_cmd_bridge_if cpu_if ();
  cfu_cmd_bridge_if core_if ();

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic mon_en = 1'b0;

  cfu_cmd_t    cmd_q[$];
  logic [31:0] rsp_q[$];
  int acc = 0, iss = 0, ret = 0;
  int stream = 0, min_cred = 0, first_cmd = -1, first_rsp = -1, last_rsp = -1;
  int stall_cnt = 0;
  logic bg_done = 1'b0;
  logic prev_stall = 1'b0;
  cfu_cmd_t prev_payload, cur_payload, in_cmd;

  always #5 clk = ~clk;

  // combinational XOR core, plus a hook for stray responses
  assign core_if.rsp_valid     = inj_valid | (core_if.cmd_valid & core_if.cmd_ready);
  assign core_if.rsp_outputs_0 = inj_valid ? inj_data : (core_if.cmd_inputs_0 ^ core_if.cmd_inputs_1);

  cfu_cmd_bridge #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .cpu                (cpu_if.slave),
    .core               (core_if.master),
    .cmd_level          (cmd_level),
    .credits            (credits),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  task automatic check_eq(input string tag, input logic [73:0] got, input logic [73:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic cfu_cmd_t rand_cmd();
    cfu_cmd_t c;
    c.function_id = 10'($urandom);
    c.inputs_0    = $urandom;
    c.inputs_1    = $urandom;
    return c;
  endfunction

  task automatic send_cmd(input cfu_cmd_t c);
    int   w = 0;
    logic f;
    cpu_if.cmd_valid       = 1'b1;
    cpu_if.cmd_function_id = c.function_id;
    cpu_if.cmd_inputs_0    = c.inputs_0;
    cpu_if.cmd_inputs_1    = c.inputs_1;
    do begin
      f = cpu_if.cmd_ready;
      cycle();
      w++;
    end while (!f && w < 300);
    cpu_if.cmd_valid = 1'b0;
    if (!f) check_eq("cmd_accept_timeout", 74'(f), 74'(1));
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while ((rsp_q.size() != 0 || cmd_q.size() != 0 || cpu_if.rsp_valid) && w < 400) begin
      cycle();
      w++;
    end
    check_eq(tag, 74'(rsp_q.size() + cmd_q.size()), 74'(0));
  endtask

  task automatic reset_checks(input string p);
    check_eq({p, "_cmd_ready"}, 74'(cpu_if.cmd_ready), 74'(1));
    check_eq({p, "_rsp_valid"}, 74'(cpu_if.rsp_valid), 74'(0));
    check_eq({p, "_core_valid"}, 74'(core_if.cmd_valid), 74'(0));
    check_eq({p, "_cmd_level"}, 74'(cmd_level), 74'(0));
    check_eq({p, "_credits"}, 74'(credits), 74'(RSP_DEPTH));
    check_eq({p, "_err"}, 74'(err_unexpected_rsp), 74'(0));
    check_eq({p, "_rsp_data"}, 74'(cpu_if.rsp_outputs_0), 74'(0));
    check_eq({p, "_core_payload"},
             {core_if.cmd_function_id, core_if.cmd_inputs_0, core_if.cmd_inputs_1}, 74'(0));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // reference model: occupancy from handshake counts, in-order data queues
  always @(posedge clk) begin
    if (mon_en && reset === 1'b1) begin
      cur_payload = {core_if.cmd_function_id, core_if.cmd_inputs_0, core_if.cmd_inputs_1};
      check_eq("cmd_level", 74'(cmd_level), 74'(acc - iss));
      check_eq("credits", 74'(credits), 74'(RSP_DEPTH - (iss - ret)));
      check_eq("cmd_ready", 74'(cpu_if.cmd_ready), 74'((acc - iss) != CMD_DEPTH));
      check_eq("core_cmd_valid", 74'(core_if.cmd_valid),
               74'(((acc - iss) != 0) && ((iss - ret) != RSP_DEPTH)));
      check_eq("rsp_valid", 74'(cpu_if.rsp_valid), 74'((iss - ret) != 0));
      check_eq("core_rsp_ready", 74'(core_if.rsp_ready), 74'(1));
      if (prev_stall) begin
        stall_cnt++;
        check_eq("payload_hold", cur_payload, prev_payload);
      end
      if (core_if.cmd_valid && core_if.cmd_ready) begin
        if (cmd_q.size() == 0) check_eq("issue_extra", 74'(cmd_q.size()), 74'(1));
        else check_eq("issue_payload", cur_payload, cmd_q.pop_front());
        iss++;
      end
      if (cpu_if.rsp_valid && cpu_if.rsp_ready) begin
        if (rsp_q.size() == 0) check_eq("rsp_extra", 74'(rsp_q.size()), 74'(1));
        else check_eq("rsp_data", 74'(cpu_if.rsp_outputs_0), 74'(rsp_q.pop_front()));
        ret++;
        if (stream != 0) begin
          if (first_rsp < 0) first_rsp = cyc;
          last_rsp = cyc;
        end
      end
      if (cpu_if.cmd_valid && cpu_if.cmd_ready) begin
        in_cmd = {cpu_if.cmd_function_id, cpu_if.cmd_inputs_0, cpu_if.cmd_inputs_1};
        cmd_q.push_back(in_cmd);
        rsp_q.push_back(in_cmd.inputs_0 ^ in_cmd.inputs_1);
        acc++;
        if (stream != 0 && first_cmd < 0) first_cmd = cyc;
      end
      if (stream != 0 && int'(credits) < min_cred) min_cred = int'(credits);
      prev_stall   = core_if.cmd_valid && !core_if.cmd_ready;
      prev_payload = cur_payload;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int r0;
    cpu_if.cmd_valid = 1'b0;
    cpu_if.cmd_function_id = 10'h0;
    cpu_if.cmd_inputs_0 = 32'h0;
    cpu_if.cmd_inputs_1 = 32'h0;
    cpu_if.rsp_ready = 1'b0;
    core_if.cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    reset = 1'b1;
    mon_en = 1'b1;
    cycle();

    // single op: fire at edge 0, rsp_valid after edge 1
    cpu_if.cmd_valid = 1'b1;
    cpu_if.cmd_function_id = 10'd3;
    cpu_if.cmd_inputs_0 = 32'h0000_00FF;
    cpu_if.cmd_inputs_1 = 32'h0F0F_0F0F;
    cycle();
    cpu_if.cmd_valid = 1'b0;
    check_eq("single_core_valid", 74'(core_if.cmd_valid), 74'(1));
    check_eq("single_rsp_early", 74'(cpu_if.rsp_valid), 74'(0));
    cycle();
    check_eq("single_rsp_valid", 74'(cpu_if.rsp_valid), 74'(1));
    check_eq("single_rsp_data", 74'(cpu_if.rsp_outputs_0), 74'(32'h0F0F_0FF0));
    cpu_if.rsp_ready = 1'b1;
    cycle();
    cpu_if.rsp_ready = 1'b0;
    check_eq("single_rsp_popped", 74'(cpu_if.rsp_valid), 74'(0));

    // back-pressure fill
    r0 = ret;
    fork
      begin
        for (int i = 0; i < 8; i++) send_cmd(rand_cmd());
      end
      begin
        repeat (12) cycle();
        check_eq("bp_credits", 74'(credits), 74'(0));
        check_eq("bp_level", 74'(cmd_level), 74'(CMD_DEPTH));
        check_eq("bp_cmd_ready", 74'(cpu_if.cmd_ready), 74'(0));
        cpu_if.rsp_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check_eq("bp_count", 74'(ret - r0), 74'(8));

    // streaming
    r0 = ret;
    min_cred = RSP_DEPTH;
    stream = 1;
    for (int i = 0; i < 16; i++) send_cmd(rand_cmd());
    drain("stream_drain");
    stream = 0;
    check_eq("stream_count", 74'(ret - r0), 74'(16));
    check_eq("stream_min_credits", 74'(min_cred), 74'(1));
    check_eq("stream_fill", 74'(first_rsp - first_cmd), 74'(2));
    check_eq("stream_rate", 74'(last_rsp - first_rsp), 74'(15));

    // slow core: ready one cycle in three
    r0 = ret;
    stall_cnt = 0;
    bg_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_cmd(rand_cmd());
        bg_done = 1'b1;
      end
      begin
        while (!bg_done) begin
          core_if.cmd_ready = (cyc % 3 == 0);
          cycle();
        end
      end
    join
    core_if.cmd_ready = 1'b1;
    drain("slow_drain");
    check_eq("slow_count", 74'(ret - r0), 74'(12));
    check_eq("slow_stalled", 74'(stall_cnt > 0), 74'(1));

    // random readies on both sides
    r0 = ret;
    bg_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) send_cmd(rand_cmd());
        bg_done = 1'b1;
      end
      begin
        while (!bg_done) begin
          core_if.cmd_ready = ($urandom_range(3) != 0);
          cpu_if.rsp_ready  = ($urandom_range(2) != 0);
          cycle();
        end
      end
    join
    core_if.cmd_ready = 1'b1;
    cpu_if.rsp_ready = 1'b1;
    drain("rand_drain");
    check_eq("rand_count", 74'(ret - r0), 74'(200));

    // stray response on an idle bridge
    inj_valid = 1'b1;
    inj_data = $urandom;
    cycle();
    inj_valid = 1'b0;
    check_eq("unexp_err", 74'(err_unexpected_rsp), 74'(1));
    check_eq("unexp_no_rsp", 74'(cpu_if.rsp_valid), 74'(0));
    repeat (5) cycle();
    check_eq("unexp_sticky", 74'(err_unexpected_rsp), 74'(1));
    check_eq("unexp_no_rsp_late", 74'(cpu_if.rsp_valid), 74'(0));

    // reset with 3 commands queued and 1 response buffered
    cpu_if.rsp_ready = 1'b0;
    send_cmd(rand_cmd());
    cycle();
    core_if.cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_cmd(rand_cmd());
    check_eq("mid_level", 74'(cmd_level), 74'(3));
    check_eq("mid_rsp_valid", 74'(cpu_if.rsp_valid), 74'(1));
    #3;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    reset_checks("midrst");
    cmd_q.delete();
    rsp_q.delete();
    acc = 0;
    iss = 0;
    ret = 0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    mon_en = 1'b1;
    core_if.cmd_ready = 1'b1;
    cpu_if.rsp_ready = 1'b1;
    cycle();
    send_cmd(rand_cmd());
    drain("post_rst_drain");
    check_eq("post_rst_count", 74'(ret), 74'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
